// File: rtl/memory_flash_line_reader.sv
// Single-line prefetch read port for the config flash; hits/out-of-range ack one cycle after accept, a miss acks one cycle after the requested beat.
// Backpressure: o_busy blocks new requests during ISSUE/FILL; i_flash_waitrequest holds the Avalon read and address stable.
module memory_flash_line_reader #(
    parameter int                ADDR_W       = 19,
    parameter int                FLASH_ADDR_W = 15,
    parameter logic [ADDR_W-1:0] FLASH_END    = 19'h059FF,
    parameter int                BURST        = 4,
    parameter bit                BYTE_SWAP    = 1'b1
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_request,
    output logic                      o_busy,
    input  logic [ADDR_W-1:0]         i_address,
    output logic                      o_ack,
    output logic [31:0]               o_data,
    input  logic                      i_flush,
    output logic                      o_flash_read,
    output logic [FLASH_ADDR_W-1:0]   o_flash_address,
    output logic [$clog2(BURST):0]    o_flash_burstcount,
    input  logic                      i_flash_waitrequest,
    input  logic [31:0]               i_flash_readdata,
    input  logic                      i_flash_readdatavalid
);

    localparam int OFF_BITS = $clog2(BURST);
    localparam int OFF_W    = (OFF_BITS > 0) ? OFF_BITS : 1;
    localparam int TAG_W    = ADDR_W - OFF_BITS;
    localparam int BC_W     = OFF_BITS + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        FILL
    } state_t;

    state_t                    state_q, state_d;
    logic [31:0]               line_buf [BURST];
    logic [TAG_W-1:0]          tag_q;
    logic [OFF_W-1:0]          off_q;
    logic [OFF_W-1:0]          beat_q;
    logic                      valid_q;
    logic                      flush_seen_q;

    logic [TAG_W-1:0]          req_tag;
    logic [OFF_W-1:0]          req_off;
    logic [FLASH_ADDR_W-1:0]   flash_base;
    logic                      accept;
    logic                      out_of_range;
    logic                      hit;
    logic                      miss;
    logic                      beat_last;
    logic                      fill_beat;

    function automatic logic [31:0] to_bus(input logic [31:0] d);
        return BYTE_SWAP ? {d[7:0], d[15:8], d[23:16], d[31:24]} : d;
    endfunction

    assign req_tag      = i_address[ADDR_W-1:OFF_BITS];
    assign req_off      = OFF_W'(i_address & ADDR_W'(BURST - 1));
    assign flash_base   = i_address[FLASH_ADDR_W-1:0] & ~FLASH_ADDR_W'(BURST - 1);
    assign accept       = i_request && (state_q == IDLE);
    assign out_of_range = i_address > FLASH_END;
    // A same-cycle flush beats a hit so the request refetches fresh data.
    assign hit          = valid_q && (tag_q == req_tag) && !i_flush;
    assign miss         = accept && !out_of_range && !hit;
    assign beat_last    = beat_q == OFF_W'(BURST - 1);
    assign fill_beat    = (state_q == FILL) && i_flash_readdatavalid;

    assign o_busy             = state_q != IDLE;
    assign o_flash_burstcount = BC_W'(BURST);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (miss) state_d = ISSUE;
            ISSUE:   if (!i_flash_waitrequest) state_d = FILL;
            FILL:    if (fill_beat && beat_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_ff @(posedge i_clk) begin
        if (fill_beat) line_buf[beat_q] <= i_flash_readdata;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            valid_q         <= 1'b0;
            flush_seen_q    <= 1'b0;
            tag_q           <= '0;
            off_q           <= '0;
            beat_q          <= '0;
            o_ack           <= 1'b0;
            o_data          <= '0;
            o_flash_read    <= 1'b0;
            o_flash_address <= '0;
        end else begin
            o_ack  <= 1'b0;
            o_data <= '0;
            unique case (state_q)
                IDLE: begin
                    if (i_flush) valid_q <= 1'b0;
                    if (accept) begin
                        if (out_of_range) begin
                            o_ack <= 1'b1;
                        end else if (hit) begin
                            o_ack  <= 1'b1;
                            o_data <= to_bus(line_buf[req_off]);
                        end else begin
                            tag_q           <= req_tag;
                            off_q           <= req_off;
                            valid_q         <= 1'b0;
                            flush_seen_q    <= 1'b0;
                            o_flash_read    <= 1'b1;
                            o_flash_address <= flash_base;
                        end
                    end
                end
                ISSUE: begin
                    if (i_flush) flush_seen_q <= 1'b1;
                    if (!i_flash_waitrequest) begin
                        o_flash_read <= 1'b0;
                        beat_q       <= '0;
                    end
                end
                FILL: begin
                    if (i_flush) flush_seen_q <= 1'b1;
                    if (i_flash_readdatavalid) begin
                        beat_q <= beat_q + 1'b1;
                        if (beat_q == off_q) begin
                            o_ack  <= 1'b1;
                            o_data <= to_bus(i_flash_readdata);
                        end
                        // A flush anywhere in this fetch, including the last beat, leaves the line invalid.
                        if (beat_last) valid_q <= !(flush_seen_q || i_flush);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_flash_line_reader.sv
// Bench for memory_flash_line_reader: a reactive Avalon flash model plus an ack-data scoreboard.
module tb_memory_flash_line_reader;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_request;
    logic        o_busy;
    logic [18:0] i_address;
    logic        o_ack;
    logic [31:0] o_data;
    logic        i_flush;
    logic        o_flash_read;
    logic [14:0] o_flash_address;
    logic [2:0]  o_flash_burstcount;
    logic        i_flash_waitrequest;
    logic [31:0] i_flash_readdata;
    logic        i_flash_readdatavalid;

    memory_flash_line_reader dut (
        .i_clk                 (i_clk),
        .i_reset_n             (i_reset_n),
        .i_request             (i_request),
        .o_busy                (o_busy),
        .i_address             (i_address),
        .o_ack                 (o_ack),
        .o_data                (o_data),
        .i_flush               (i_flush),
        .o_flash_read          (o_flash_read),
        .o_flash_address       (o_flash_address),
        .o_flash_burstcount    (o_flash_burstcount),
        .i_flash_waitrequest   (i_flash_waitrequest),
        .i_flash_readdata      (i_flash_readdata),
        .i_flash_readdatavalid (i_flash_readdatavalid)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] sb [$];

    int          wait_n = 0;
    int          flash_bursts = 0;
    int          read_hi_cycles = 0;
    logic        read_dropped = 1'b0;
    logic [14:0] last_base = '0;
    int          beat_cyc [4];

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial forever begin
        @(posedge i_clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
        $fatal(1);
    end

    function automatic logic [31:0] flash_word(input logic [14:0] a);
        logic [12:0] line;
        line = a[14:2] - 13'd1;
        return 32'h11223344 + 32'(a[1:0]) * 32'h11111111 + 32'(line) * 32'h00010203;
    endfunction

    function automatic logic [31:0] swap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    function automatic logic [31:0] expect_data(input logic [18:0] a);
        if (a > 19'h059FF) return 32'h0;
        return swap32(flash_word(a[14:0]));
    endfunction

    // Flash model: honours wait_n cycles of waitrequest, then streams four beats back to back.
    initial begin
        i_flash_waitrequest   = 1'b0;
        i_flash_readdatavalid = 1'b0;
        i_flash_readdata      = '0;
        forever begin
            @(posedge i_clk); #1;
            if (i_reset_n === 1'b1 && o_flash_read === 1'b1) begin
                last_base = o_flash_address;
                flash_bursts++;
                read_hi_cycles = 1;
                if (wait_n > 0) i_flash_waitrequest = 1'b1;
                for (int n = 1; n <= wait_n; n++) begin
                    @(posedge i_clk); #1;
                    if (o_flash_read === 1'b1 && o_flash_address === last_base) read_hi_cycles++;
                    if (n == wait_n) i_flash_waitrequest = 1'b0;
                end
                @(posedge i_clk); #1;
                read_dropped = (o_flash_read === 1'b0);
                for (int k = 0; k < 4; k++) begin
                    if (i_reset_n !== 1'b1) break;
                    i_flash_readdatavalid = 1'b1;
                    i_flash_readdata      = flash_word(last_base + 15'(k));
                    beat_cyc[k]           = cyc;
                    @(posedge i_clk); #1;
                end
                i_flash_readdatavalid = 1'b0;
                i_flash_readdata      = '0;
            end
        end
    end

    // Scoreboard: every ack pops one expected word; o_data must be zero whenever ack is low.
    initial forever begin
        logic [31:0] exp_d;
        @(negedge i_clk);
        checks++;
        if (o_ack === 1'b1) begin
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: got ack with data %h, required no ack", o_data);
            end else begin
                exp_d = sb.pop_front();
                if (o_data !== exp_d) begin
                    errors++;
                    $display("FAIL ack_data: got %h, required %h", o_data, exp_d);
                end
            end
        end else if (o_data !== 32'h0) begin
            errors++;
            $display("FAIL idle_data: got %h, required 00000000 while ack low", o_data);
        end
    end

    task automatic do_req(input logic [18:0] a, input logic fl);
        sb.push_back(expect_data(a));
        i_request = 1'b1;
        i_address = a;
        i_flush   = fl;
        @(posedge i_clk); #1;
        i_request = 1'b0;
        i_flush   = 1'b0;
    endtask

    task automatic wait_ack(input string name, output int c);
        c = -1;
        for (int i = 0; i < 60; i++) begin
            if (o_ack === 1'b1) begin
                c = cyc;
                break;
            end
            @(posedge i_clk); #1;
        end
        checks++;
        if (c < 0) begin
            errors++;
            $display("FAIL %s_ack_timeout: got no ack in 60 cycles, required ack", name);
        end
    endtask

    task automatic wait_idle(input string name, output int c);
        c = -1;
        for (int i = 0; i < 60; i++) begin
            if (o_busy === 1'b0) begin
                c = cyc;
                break;
            end
            @(posedge i_clk); #1;
        end
        checks++;
        if (c < 0) begin
            errors++;
            $display("FAIL %s_idle_timeout: got busy for 60 cycles, required idle", name);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({o_ack, o_flash_read, o_busy} !== 3'b000 || o_data !== 32'h0) begin
            errors++;
            $display("FAIL %s: got ack=%b read=%b busy=%b data=%h, required all 0",
                     name, o_ack, o_flash_read, o_busy, o_data);
        end
    endtask

    task automatic test_reset;
        i_reset_n = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check_reset_outputs("reset_outputs");
        checks++;
        if (o_flash_burstcount !== 3'd4) begin
            errors++;
            $display("FAIL burstcount: got %0d, required 4", o_flash_burstcount);
        end
        i_reset_n = 1'b1;
        @(posedge i_clk); #1;
    endtask

    task automatic test_cold_miss;
        int ack_c, idle_c;
        do_req(19'h00006, 1'b0);
        checks++;
        if (o_flash_read !== 1'b1 || o_flash_address !== 15'h0004 || o_busy !== 1'b1
            || o_flash_burstcount !== 3'd4) begin
            errors++;
            $display("FAIL cold_issue: got read=%b addr=%h busy=%b bc=%0d, required 1 0004 1 4",
                     o_flash_read, o_flash_address, o_busy, o_flash_burstcount);
        end
        wait_ack("cold", ack_c);
        checks++;
        if (ack_c != beat_cyc[2] + 1 || o_data !== 32'h66554433) begin
            errors++;
            $display("FAIL cold_ack: got cycle %0d data %h, required cycle %0d data 66554433",
                     ack_c, o_data, beat_cyc[2] + 1);
        end
        wait_idle("cold", idle_c);
        checks++;
        if (idle_c != beat_cyc[3] + 1 || read_dropped !== 1'b1) begin
            errors++;
            $display("FAIL cold_busy_fall: got cycle %0d dropped=%b, required cycle %0d dropped=1",
                     idle_c, read_dropped, beat_cyc[3] + 1);
        end
    endtask

    task automatic test_back_to_back;
        logic [18:0] addrs [3];
        int b0;
        addrs[0] = 19'h4; addrs[1] = 19'h5; addrs[2] = 19'h7;
        b0 = flash_bursts;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(expect_data(addrs[i]));
            i_request = 1'b1;
            i_address = addrs[i];
            @(posedge i_clk); #1;
            checks++;
            if (o_ack !== 1'b1 || o_flash_read !== 1'b0 || o_busy !== 1'b0) begin
                errors++;
                $display("FAIL b2b_hit_%0d: got ack=%b read=%b busy=%b, required 1 0 0",
                         i, o_ack, o_flash_read, o_busy);
            end
        end
        i_request = 1'b0;
        @(posedge i_clk); #1;
        checks++;
        if (flash_bursts != b0) begin
            errors++;
            $display("FAIL b2b_no_flash: got %0d bursts, required %0d", flash_bursts, b0);
        end
    endtask

    task automatic test_out_of_range;
        logic [18:0] addrs [2];
        int b0;
        addrs[0] = 19'h05A00; addrs[1] = 19'h7FFFF;
        b0 = flash_bursts;
        for (int i = 0; i < 2; i++) begin
            do_req(addrs[i], 1'b0);
            checks++;
            if (o_ack !== 1'b1 || o_data !== 32'h0 || o_flash_read !== 1'b0 || o_busy !== 1'b0) begin
                errors++;
                $display("FAIL oor_%0d: got ack=%b data=%h read=%b busy=%b, required 1 0 0 0",
                         i, o_ack, o_data, o_flash_read, o_busy);
            end
        end
        do_req(19'h4, 1'b0);
        checks++;
        if (o_ack !== 1'b1 || flash_bursts != b0) begin
            errors++;
            $display("FAIL oor_line_kept: got ack=%b bursts=%0d, required ack=1 bursts=%0d",
                     o_ack, flash_bursts, b0);
        end
    endtask

    task automatic test_waitrequest;
        int ack_c, idle_c;
        wait_n = 5;
        do_req(19'h10, 1'b0);
        wait_ack("wait", ack_c);
        checks++;
        if (read_hi_cycles != 6 || last_base !== 15'h0010 || ack_c != beat_cyc[0] + 1) begin
            errors++;
            $display("FAIL wait_stable: got %0d cycles base %h ack cycle %0d, required 6 0010 %0d",
                     read_hi_cycles, last_base, ack_c, beat_cyc[0] + 1);
        end
        wait_idle("wait", idle_c);
        wait_n = 0;
    endtask

    task automatic test_flush;
        int ack_c, idle_c, b0;
        b0 = flash_bursts;
        do_req(19'h21, 1'b0);
        for (int i = 0; i < 20 && o_flash_read === 1'b1; i++) begin
            @(posedge i_clk); #1;
        end
        i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        wait_ack("flush_fill", ack_c);
        wait_idle("flush_fill", idle_c);
        do_req(19'h21, 1'b0);
        checks++;
        if (o_ack !== 1'b0 || o_flash_read !== 1'b1) begin
            errors++;
            $display("FAIL flush_reread_miss: got ack=%b read=%b, required 0 1", o_ack, o_flash_read);
        end
        wait_ack("flush_reread", ack_c);
        wait_idle("flush_reread", idle_c);
        do_req(19'h22, 1'b1);
        checks++;
        if (o_ack !== 1'b0 || o_flash_read !== 1'b1) begin
            errors++;
            $display("FAIL flush_beats_hit: got ack=%b read=%b, required 0 1", o_ack, o_flash_read);
        end
        wait_ack("flush_idle", ack_c);
        wait_idle("flush_idle", idle_c);
        do_req(19'h23, 1'b0);
        checks++;
        if (o_ack !== 1'b1 || flash_bursts != b0 + 3) begin
            errors++;
            $display("FAIL flush_refill_hit: got ack=%b bursts=%0d, required 1 %0d",
                     o_ack, flash_bursts, b0 + 3);
        end
    endtask

    task automatic test_reset_mid_fill;
        int ack_c, idle_c, b0;
        do_req(19'h13, 1'b0);
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        i_reset_n = 1'b0;
        @(posedge i_clk); #1;
        check_reset_outputs("midfill_reset_a");
        @(posedge i_clk); #1;
        check_reset_outputs("midfill_reset_b");
        sb.delete();
        i_reset_n = 1'b1;
        @(posedge i_clk); #1;
        b0 = flash_bursts;
        do_req(19'h4, 1'b0);
        checks++;
        if (o_ack !== 1'b0 || o_flash_read !== 1'b1 || o_flash_address !== 15'h0004) begin
            errors++;
            $display("FAIL post_reset_miss: got ack=%b read=%b addr=%h, required 0 1 0004",
                     o_ack, o_flash_read, o_flash_address);
        end
        wait_ack("post_reset", ack_c);
        wait_idle("post_reset", idle_c);
        checks++;
        if (flash_bursts != b0 + 1) begin
            errors++;
            $display("FAIL post_reset_burst: got %0d bursts, required %0d", flash_bursts, b0 + 1);
        end
    endtask

    initial begin
        i_reset_n = 1'b0;
        i_request = 1'b0;
        i_address = '0;
        i_flush   = 1'b0;
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_out_of_range();
        test_waitrequest();
        test_flush();
        test_reset_mid_fill();
        repeat (2) @(posedge i_clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending acks, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
